mc_ctrl_fsm: RTL

- Main control sequencer for the multicycle RV32I core.
- Replaces the single-cycle control path: steps one instruction through fetch, decode, execute, memory and writeback states over several clocks.
- Drives the shared ALU, memory port, IR and register-file enables, and instantiates the existing alu_decoder for alucontrol.
- Stalls on a memory ready handshake; parks in a sticky trap state on an unsupported opcode.

---
 rtl/mc_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control sequencer plus its ALU control decoder.
//
// alu_decoder
//   opb5_i        in  1  instr[5], separates R-type sub from I-type add
//   funct3_i      in  3  instr[14:12]
//   funct7b5_i    in  1  instr[30]
//   aluop_i       in  2  00 add, 01 sub, 10 decode from funct fields
//   alucontrol_o  out 3  ALU operation select
//
// mc_ctrl_fsm
//   clk, reset    in     rising-edge clock, async active-high reset
//   op, funct3,   in     instruction fields from the IR
//   funct7b5
//   zero          in     ALU zero flag, qualifies beq
//   mem_ready     in     memory finished the current access
//   mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite   out  enables
//   resultsrc, alusrca, alusrcb, immsrc                      out  muxes
//   alucontrol    out    from alu_decoder
//   illegal       out    sticky trap flag
//   retire        out    one-cycle pulse per completed instruction

module alu_decoder (
    input  logic       opb5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] aluop_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = 3'b000;
        case (aluop_i)
            2'b00: alucontrol_o = 3'b000;
            2'b01: alucontrol_o = 3'b001;
            default: begin
                case (funct3_i)
                    3'b000: begin
                        // Only R-type (op[5]=1) uses funct7b5 to select sub.
                        if (opb5_i && funct7b5_i) begin
                            alucontrol_o = 3'b001;
                        end else begin
                            alucontrol_o = 3'b000;
                        end
                    end
                    3'b010:  alucontrol_o = 3'b101;
                    3'b110:  alucontrol_o = 3'b011;
                    3'b111:  alucontrol_o = 3'b010;
                    default: alucontrol_o = 3'b000;
                endcase
            end
        endcase
    end

endmodule

module mc_ctrl_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] immsrc,
    output logic       illegal,
    output logic       retire
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       ready;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        mem_req   = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        illegal   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                resultsrc = 2'b10;
                // PC+4 path only matters in the cycle the fetch lands;
                // while stalled the whole datapath is kept quiet.
                if (ready) begin
                    alusrcb  = 2'b10;
                    irwrite  = 1'b1;
                    pcupdate = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU computes the branch/jump target from OldPC + imm.
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                if (op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = ready;
                state_d  = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // Target was latched in DECODE; ALU now forms the link PC+4.
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_dec (
        .opb5_i       (op[5]),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .aluop_i      (aluop),
        .alucontrol_o (alucontrol)
    );

endmodule
